// File: rtl/ru_pkg.sv
// Shared Q4.12 constants and the saturation helper for the softmax reduce/update unit.
package ru_pkg;
   localparam int WIDTH = 16;
   localparam int FRAC  = 12;
   localparam logic signed [WIDTH-1:0] LOG2E = 16'sh1715;
   localparam logic signed [WIDTH-1:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [WIDTH-1:0] Q_MIN = 16'sh8000;

   function automatic logic signed [WIDTH-1:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return Q_MAX;
      else if (v < -32'sd32768)
         return Q_MIN;
      else
         return v[WIDTH-1:0];
   endfunction
endpackage

// File: rtl/ru_pow2.sv
// Piecewise-linear 2^x on a Q4.12 operand: mantissa (1+f) shifted by the integer part.
import ru_pkg::*;

module ru_pow2 (
   input  logic [WIDTH-1:0] scaled,
   output logic [WIDTH-1:0] pow_out
);
   logic [12:0] m;
   logic [19:0] r;
   logic [3:0]  sh;

   assign m = {1'b1, scaled[FRAC-1:0]};

   always_comb begin
      r       = '0;
      sh      = '0;
      pow_out = '0;
      if (!scaled[WIDTH-1]) begin
         r       = {7'd0, m} << scaled[14:12];
         pow_out = (r > 20'h07FFF) ? Q_MAX : r[WIDTH-1:0];
      end else begin
         // two's-complement negate of n; n=-8 yields 4'b1000 = 8 as unsigned
         sh      = ~scaled[15:12] + 4'd1;
         r       = {7'd0, m} >> sh;
         pow_out = r[WIDTH-1:0];
      end
   end
endmodule

// File: rtl/ru.sv
// Softmax reduce/update: saturated difference, optional log2(e) scale, 2^x, one-cycle latency.
// Define RU_ROUND_EN to round the log2(e) product to nearest instead of flooring.
import ru_pkg::*;

module ru (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic             sel_mult,
   input  logic             sel_mux,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_0,
   output logic [WIDTH-1:0] out_1
);
   localparam int STAGES = 1;

   logic signed [16:0]      diff_w;
   logic signed [WIDTH-1:0] diff;
   logic signed [31:0]      prod;
   logic signed [31:0]      prod_adj;
   logic signed [WIDTH-1:0] scaled;
   logic [WIDTH-1:0]        pow_w;
   logic [STAGES-1:0]       vld_pipe;

   always_comb begin
      if (sel_mux)
         diff_w = {in_1[WIDTH-1], in_1} - {in_0[WIDTH-1], in_0};
      else
         diff_w = {in_0[WIDTH-1], in_0} - {in_1[WIDTH-1], in_1};
   end

   assign diff = sat16({{15{diff_w[16]}}, diff_w});
   assign prod = diff * LOG2E;

`ifdef RU_ROUND_EN
   assign prod_adj = prod + 32'sd2048;
`else
   assign prod_adj = prod;
`endif

   assign scaled = sel_mult ? sat16(prod_adj >>> FRAC) : diff;

   ru_pow2 u_pow2 (
      .scaled (scaled),
      .pow_out(pow_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         out_0    <= '0;
         out_1    <= '0;
      end else begin
         vld_pipe <= STAGES'({vld_pipe, in_valid});
         if (in_valid) begin
            out_0 <= scaled;
            out_1 <= pow_w;
         end
      end
   end

   assign out_valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_ru.sv
// Directed-vector bench for ru with hand-computed Q4.12 expectations.
module tb_ru;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_0, in_1;
   logic        sel_mult, sel_mux;
   logic        out_valid;
   logic [15:0] out_0, out_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ru dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_0     (in_0),
      .in_1     (in_1),
      .sel_mult (sel_mult),
      .sel_mux  (sel_mux),
      .out_valid(out_valid),
      .out_0    (out_0),
      .out_1    (out_1)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b,
                        input logic mux, input logic mult, input logic v);
      @(negedge clk);
      in_0 = a; in_1 = b; sel_mux = mux; sel_mult = mult; in_valid = v;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] s1_out0;

   initial begin
`ifdef RU_ROUND_EN
      s1_out0 = 16'hE326;
`else
      s1_out0 = 16'hE325;
`endif
      rst = 1'b1; in_valid = 1'b0; in_0 = '0; in_1 = '0; sel_mult = 1'b0; sel_mux = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_out_0", out_0, 16'h0000);
      chk("rst_out_1", out_1, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // stage1 then stage2 back-to-back
      drive(16'h2400, 16'h1000, 1'b1, 1'b1, 1'b1);
      step();
      chk("s1_valid", {15'd0, out_valid}, 16'h0001);
      chk("s1_out_0", out_0, s1_out0);
      chk("s1_out_1", out_1, 16'h04C9);
      drive(16'h1800, 16'hE316, 1'b0, 1'b0, 1'b1);
      step();
      chk("s2_valid", {15'd0, out_valid}, 16'h0001);
      chk("s2_out_0", out_0, 16'h34EA);
      chk("s2_out_1", out_1, 16'h7FFF);

      // gap: valid drops, data holds despite changed inputs
      drive(16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0);
      step();
      chk("gap_valid", {15'd0, out_valid}, 16'h0000);
      chk("gap_hold_0", out_0, 16'h34EA);
      chk("gap_hold_1", out_1, 16'h7FFF);

      drive(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
      step();
      chk("zero_m0_out_0", out_0, 16'h0000);
      chk("zero_m0_out_1", out_1, 16'h1000);
      drive(16'h1000, 16'h1000, 1'b1, 1'b1, 1'b1);
      step();
      chk("zero_m1_out_0", out_0, 16'h0000);
      chk("zero_m1_out_1", out_1, 16'h1000);

      drive(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1);
      step();
      chk("dsat_hi_out_0", out_0, 16'h7FFF);
      chk("dsat_hi_out_1", out_1, 16'h7FFF);

      // -8.0: n=-8, m=4096>>8
      drive(16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1);
      step();
      chk("dsat_lo_out_0", out_0, 16'h8000);
      chk("dsat_lo_out_1", out_1, 16'h0010);

      // 32767*5909>>12 overflows Q4.12
      drive(16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1);
      step();
      chk("msat_out_0", out_0, 16'h7FFF);
      chk("msat_out_1", out_1, 16'h7FFF);

      // -1.0 scaled by 1: 2^-1 = 0.5
      drive(16'h0000, 16'h1000, 1'b0, 1'b0, 1'b1);
      step();
      chk("neg1_out_0", out_0, 16'hF000);
      chk("neg1_out_1", out_1, 16'h0800);

      // async reset mid-stream, checked before any clock edge
      drive(16'h2400, 16'h1000, 1'b1, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_valid", {15'd0, out_valid}, 16'h0000);
      chk("mrst_out_0", out_0, 16'h0000);
      chk("mrst_out_1", out_1, 16'h0000);
      step();
      chk("mrst_held_0", out_0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      chk("mrst_discard_valid", {15'd0, out_valid}, 16'h0000);
      chk("mrst_discard_0", out_0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
